// File: rtl/button_pio_debounced_pkg.sv
// Shared definitions for the debounced push-button PIO: register map,
// edge-capture mode codes and the edge-event helper.
package button_pio_debounced_pkg;

    localparam int unsigned BUS_W = 32;

    // Word offsets of the four CPU-visible registers.
    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,   // debounced, normalised levels
        ADDR_RAW  = 2'd1,   // synchroniser output, normalised
        ADDR_MASK = 2'd2,   // irq enable per bit
        ADDR_EDGE = 2'd3    // captured events, write 1 to clear
    } reg_addr_e;

    // Which transitions of the debounced level are captured as events.
    localparam int unsigned EDGE_PRESS   = 0;
    localparam int unsigned EDGE_RELEASE = 1;
    localparam int unsigned EDGE_BOTH    = 2;

    // One-cycle event vector from the current and previous debounced level.
    function automatic logic [BUS_W-1:0] edge_events(
        input int unsigned      mode,
        input logic [BUS_W-1:0] level,
        input logic [BUS_W-1:0] prev
    );
        case (mode)
            EDGE_RELEASE: return ~level & prev;
            EDGE_BOTH:    return level ^ prev;
            default:      return level & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/button_pio_debounced_if.sv
// Avalon-MM slave bus of the button PIO (word addressed, write-only strobe,
// registered read data).
interface button_pio_debounced_if;
    import button_pio_debounced_pkg::*;

    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [BUS_W-1:0] writedata;
    logic [BUS_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/button_debounce_bit.sv
// One button input: synchroniser chain, consecutive-mismatch counter and the
// accepted (stable) level. Works on raw pin polarity; RELEASED is the raw
// level of an untouched key.
module button_debounce_bit #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          RELEASED        = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    output logic sync_o,
    output logic stable_o
);
    localparam int unsigned            CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;

    // Shift the pin through the synchroniser; count mismatches and accept the
    // new level on the DEBOUNCE_CYCLES-th one. Any agreement restarts the count,
    // so the counter tops out at CNT_LAST and never wraps.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin_i};
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[SYNC_STAGES-1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[SYNC_STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset forces "released" so a held key is re-detected.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{RELEASED}};
            cnt_q    <= '0;
            stable_q <= RELEASED;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign sync_o   = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

endmodule

// File: rtl/button_pio_debounced.sv
// Debounced push-button PIO: per-bit debouncers, polarity normalisation,
// edge capture with write-1-to-clear, irq mask and registered read mux.
module button_pio_debounced
    import button_pio_debounced_pkg::*;
#(
    parameter int unsigned WIDTH           = 7,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned EDGE_MODE       = EDGE_PRESS
) (
    input  logic                   clk,
    input  logic                   reset_n,
    button_pio_debounced_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);
    localparam logic [WIDTH-1:0] POL = {WIDTH{ACTIVE_LOW}};

    logic [WIDTH-1:0] sync_raw, stable_raw;
    logic [WIDTH-1:0] raw_lvl, level, evt, clr;
    logic [BUS_W-1:0] evt_full;
    logic             wr_en;

    logic [WIDTH-1:0] prev_q, mask_q, mask_d, edge_q, edge_d;
    logic             irq_q, irq_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        button_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RELEASED        (ACTIVE_LOW)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (in_port[i]),
            .sync_o   (sync_raw[i]),
            .stable_o (stable_raw[i])
        );
    end

    // Normalise so that 1 always means pressed.
    assign raw_lvl = sync_raw ^ POL;
    assign level   = stable_raw ^ POL;

    // Bus decode, event capture (set beats clear), irq from next-state values
    // so the output flop tracks EDGE/MASK in the same cycle, and the read mux.
    always_comb begin
        wr_en    = bus.chipselect && !bus.write_n;
        evt_full = edge_events(EDGE_MODE, BUS_W'(level), BUS_W'(prev_q));
        evt      = evt_full[WIDTH-1:0];
        mask_d   = mask_q;
        clr      = '0;
        if (wr_en) begin
            case (reg_addr_e'(bus.address))
                ADDR_MASK: mask_d = bus.writedata[WIDTH-1:0];
                ADDR_EDGE: clr    = bus.writedata[WIDTH-1:0];
                default:   ;
            endcase
        end
        edge_d  = (edge_q & ~clr) | evt;
        irq_d   = |(edge_d & mask_d);
        rdata_d = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA: rdata_d[WIDTH-1:0] = level;
            ADDR_RAW:  rdata_d[WIDTH-1:0] = raw_lvl;
            ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rdata_d[WIDTH-1:0] = edge_q;
        endcase
    end

    // Register state; prev_q holds last cycle's level for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            prev_q  <= level;
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_button_pio_debounced.sv
// Bench for button_pio_debounced: register table, hand-written press/bounce/
// irq/collision/reset sequences, then random traffic against a window model.
module tb_button_pio_debounced;

    localparam int W  = 7;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int EM = 0;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '1;
    logic         irq;

    button_pio_debounced_if bus_if ();

    button_pio_debounced #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1),
        .EDGE_MODE       (EM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // A level is accepted once the pin, seen through S flops, has shown the
    // opposite value for D clocks in a row. Pin history since reset is kept in
    // a queue; anything before reset counts as released (0).
    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable, m_mask, m_edge, m_rise;
    logic [31:0]  m_rd;
    logic         m_irq;

    function automatic logic [W-1:0] pin_at(input int k);
        if (k >= 1 && k <= hist.size()) return hist[k-1];
        return '0;
    endfunction

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_step();
        logic [W-1:0] win_hi, win_lo, nxt, ev, clr, new_mask, new_edge;
        logic         we;
        int           n;
        if (!reset_n) begin
            hist.delete();
            m_stable = '0; m_mask = '0; m_edge = '0; m_rise = '0;
            m_rd = '0; m_irq = 1'b0;
        end else begin
            hist.push_back(~in_port);
            n = hist.size();
            case (bus_if.address)
                2'd0:    m_rd = 32'(m_stable);
                2'd1:    m_rd = 32'(pin_at(n - S));
                2'd2:    m_rd = 32'(m_mask);
                default: m_rd = 32'(m_edge);
            endcase
            win_hi = '1;
            win_lo = '1;
            for (int k = n - S - D + 1; k <= n - S; k++) begin
                win_hi &= pin_at(k);
                win_lo &= ~pin_at(k);
            end
            nxt = (m_stable | win_hi) & ~win_lo;
            case (EM)
                1:       ev = ~nxt & m_stable;
                2:       ev = nxt ^ m_stable;
                default: ev = nxt & ~m_stable;
            endcase
            we       = bus_if.chipselect && !bus_if.write_n;
            new_mask = (we && bus_if.address == 2'd2) ? bus_if.writedata[W-1:0] : m_mask;
            clr      = (we && bus_if.address == 2'd3) ? bus_if.writedata[W-1:0] : '0;
            new_edge = (m_edge & ~clr) | m_rise;
            m_irq    = |(new_edge & new_mask);
            m_rise   = ev;
            m_stable = nxt;
            m_edge   = new_edge;
            m_mask   = new_mask;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle(input logic [1:0] a);
        bus_if.address    = a;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        tick();
        idle(a);
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle(2'd0);
        // Each vector is one clock; readdata shows the register selected in that clock.
        tbl[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};
        tbl[1]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};
        tbl[2]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};
        tbl[3]  = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};
        tbl[4]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h00, 1'b0};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h7F, 1'b0};
        tbl[6]  = '{2'd0, 1'b1, 1'b0, 32'h55,        32'h00, 1'b0};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};
        tbl[8]  = '{2'd3, 1'b1, 1'b0, 32'h7F,        32'h00, 1'b0};
        tbl[9]  = '{2'd2, 1'b0, 1'b0, 32'h0,         32'h7F, 1'b0};
        tbl[10] = '{2'd2, 1'b1, 1'b1, 32'h0,         32'h7F, 1'b0};
        tbl[11] = '{2'd2, 1'b1, 1'b0, 32'h0,         32'h7F, 1'b0};
        tbl[12] = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h00, 1'b0};

        // Reset
        ticks(3);
        check("reset_rd", bus_if.readdata, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        // Register table
        for (int i = 0; i < 13; i++) begin
            bus_if.address    = tbl[i].addr;
            bus_if.chipselect = tbl[i].cs;
            bus_if.write_n    = tbl[i].wn;
            bus_if.writedata  = tbl[i].wd;
            tick();
            check($sformatf("tbl%0d_rd", i), bus_if.readdata, tbl[i].exp_rd);
            check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end
        idle(2'd0);

        // Clean press on bit 0: stable after 6 clocks, visible one read-cycle later
        in_port[0] = 1'b0;
        ticks(6);
        check("press_data_at6", bus_if.readdata, 32'h00);
        tick();
        check("press_data_at7", bus_if.readdata, 32'h01);
        idle(2'd3);
        tick();
        check("press_edge", bus_if.readdata, 32'h01);
        check("press_irq_masked", 32'(irq), 32'h0);
        in_port[0] = 1'b1;
        idle(2'd0);
        ticks(8);
        check("release_data", bus_if.readdata, 32'h00);
        idle(2'd3);
        tick();
        check("release_not_captured", bus_if.readdata, 32'h01);
        wr(2'd3, 32'h01);
        tick();
        check("w1c_edge", bus_if.readdata, 32'h00);

        // Bounce on bit 2: toggling every 2 clocks never settles
        idle(2'd0);
        for (int i = 0; i < 10; i++) begin
            in_port[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(2);
        end
        in_port[2] = 1'b1;
        ticks(10);
        check("bounce_data", bus_if.readdata, 32'h00);
        idle(2'd3);
        tick();
        check("bounce_edge", bus_if.readdata, 32'h00);

        // IRQ: masked press raises irq, W1C drops it the next cycle
        wr(2'd2, 32'h01);
        idle(2'd0);
        in_port[0] = 1'b0;
        ticks(6);
        check("irq_before", 32'(irq), 32'h0);
        tick();
        check("irq_raised", 32'(irq), 32'h1);
        wr(2'd3, 32'h01);
        check("irq_cleared", 32'(irq), 32'h0);
        tick();
        check("irq_edge_cleared", bus_if.readdata, 32'h00);
        in_port[0] = 1'b1;
        ticks(8);

        // Collision: W1C on bit 3 in the very clock its new event lands
        wr(2'd2, 32'h08);
        idle(2'd0);
        in_port[3] = 1'b0;
        ticks(7);
        check("coll_irq_pre", 32'(irq), 32'h1);
        in_port[3] = 1'b1;
        ticks(10);
        check("coll_irq_held", 32'(irq), 32'h1);
        in_port[3] = 1'b0;
        ticks(6);
        wr(2'd3, 32'h08);
        check("coll_irq_after", 32'(irq), 32'h1);
        tick();
        check("coll_edge", bus_if.readdata, 32'h08);
        wr(2'd3, 32'h08);
        check("coll_clear_irq", 32'(irq), 32'h0);
        wr(2'd2, 32'h00);
        in_port[3] = 1'b1;
        ticks(8);

        // Reset mid-count with bit 1 held through reset
        idle(2'd0);
        in_port[1] = 1'b0;
        ticks(4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ticks(6);
        check("rst_data_at6", bus_if.readdata, 32'h00);
        tick();
        check("rst_data_at7", bus_if.readdata, 32'h02);
        idle(2'd3);
        tick();
        check("rst_edge", bus_if.readdata, 32'h02);
        idle(2'd2);
        tick();
        check("rst_mask", bus_if.readdata, 32'h00);
        check("rst_irq", 32'(irq), 32'h0);

        // Random traffic against the model; pins hold for 1..8 clocks
        begin
            int hold[W];
            for (int b = 0; b < W; b++) hold[b] = 0;
            for (int c = 0; c < 1500; c++) begin
                for (int b = 0; b < W; b++) begin
                    if (hold[b] == 0) begin
                        in_port[b] = 1'($urandom_range(0, 1));
                        hold[b]    = $urandom_range(1, 8);
                    end
                    hold[b]--;
                end
                bus_if.address    = 2'($urandom_range(0, 3));
                bus_if.chipselect = 1'($urandom_range(0, 1));
                bus_if.write_n    = ($urandom_range(0, 3) != 0);
                bus_if.writedata  = $urandom;
                tick();
                check($sformatf("rand%0d_rd", c), bus_if.readdata, m_rd);
                check($sformatf("rand%0d_irq", c), 32'(irq), 32'(m_irq));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
